// File: rtl/jtframe_hps_pkg.sv
// jtframe_hps_pkg
// Shared definitions for the HPS download router: default menu indices,
// data-width legality check and FIFO entry width.
package jtframe_hps_pkg;

   localparam logic [7:0] HPS_IDX_ROM   = 8'd0;
   localparam logic [7:0] HPS_IDX_MOD   = 8'd1;
   localparam logic [7:0] HPS_IDX_NVRAM = 8'd2;
   localparam logic [7:0] HPS_IDX_DIPSW = 8'd254;

   // Only 8- and 16-bit HPS buses exist on MiSTer.
   function automatic bit dw_legal(input int unsigned dw);
      return (dw == 8) || (dw == 16);
   endfunction

   // FIFO entry layout: {ram_flag, addr, data}
   function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
      return 1 + aw + dw;
   endfunction

endpackage

// File: rtl/jtframe_hps_fifo.sv
// jtframe_hps_fifo
// Generic synchronous FIFO, depth 2**FIFO_AW, head word shown on dout_o.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i, din_i   write request/data (dropped when full)
//   pop_i           read request (ignored when empty)
//   dout_o          head entry (undefined while empty)
//   count_o         number of stored entries
//   full_o, empty_o occupancy flags
module jtframe_hps_fifo #(
   parameter int unsigned W       = 8,
   parameter int unsigned FIFO_AW = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic [W-1:0]       din_i,
   input  logic               pop_i,
   output logic [W-1:0]       dout_o,
   output logic [FIFO_AW:0]   count_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;

   logic [W-1:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic                 push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage needs no reset: contents are only visible while count_q > 0.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/jtframe_hps_loader.sv
// jtframe_hps_loader
// Routes HPS writes by menu index: ROM/NVRAM words go through a FIFO to the
// ioctl loader interface with back-pressure, core_mod and DIP bytes are
// stored locally, and ROM download length is reported after the last word
// has been accepted downstream.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   hps_download/index/wr/addr/dout  HPS side write port
//   hps_wait                     stall request to HPS
//   ioctl_wr/ram/addr/dout       loader side word, ioctl_rdy accepts it
//   downloading, dwn_len, dwn_empty  ROM download status
//   core_mod, dipsw              configuration registers
module jtframe_hps_loader
   import jtframe_hps_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned AW        = 27,
   parameter int unsigned FIFO_AW   = 2,
   parameter int unsigned DIPB      = 4,
   parameter logic [7:0]  IDX_ROM   = HPS_IDX_ROM,
   parameter logic [7:0]  IDX_MOD   = HPS_IDX_MOD,
   parameter logic [7:0]  IDX_NVRAM = HPS_IDX_NVRAM,
   parameter logic [7:0]  IDX_DIPSW = HPS_IDX_DIPSW,
   parameter logic [6:0]  MOD_RST   = 7'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              hps_download,
   input  logic [7:0]        hps_index,
   input  logic              hps_wr,
   input  logic [AW-1:0]     hps_addr,
   input  logic [DW-1:0]     hps_dout,
   output logic              hps_wait,
   output logic              ioctl_wr,
   output logic              ioctl_ram,
   output logic [AW-1:0]     ioctl_addr,
   output logic [DW-1:0]     ioctl_dout,
   input  logic              ioctl_rdy,
   output logic              downloading,
   output logic [AW-1:0]     dwn_len,
   output logic              dwn_empty,
   output logic [6:0]        core_mod,
   output logic [8*DIPB-1:0] dipsw
);

   localparam int unsigned EW    = entry_w(AW, DW);
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;
   localparam int unsigned STEP  = dw_legal(DW) ? DW / 8 : 1;

   logic          is_rom, is_nvram, push, pop, full, empty, rise, fall;
   logic [EW-1:0] fifo_dout;
   logic [CW-1:0] count, count_nxt;

   logic              hps_wait_q, hps_wait_d;
   logic              last_dwn_q;
   logic              downloading_q, downloading_d;
   logic              pend_end_q, pend_end_d;
   logic              wr_seen_q, wr_seen_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     dwn_len_q, dwn_len_d;
   logic              dwn_empty_q, dwn_empty_d;
   logic [6:0]        core_mod_q, core_mod_d;
   logic [8*DIPB-1:0] dipsw_q, dipsw_d;

   assign is_rom   = hps_wr && (hps_index == IDX_ROM);
   assign is_nvram = hps_wr && (hps_index == IDX_NVRAM);
   assign push     = is_rom || is_nvram;
   assign pop      = ioctl_wr && ioctl_rdy;
   assign rise     = hps_download && !last_dwn_q;
   assign fall     = !hps_download && last_dwn_q;

   jtframe_hps_fifo #(
      .W       (EW),
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   ({is_nvram, hps_addr, hps_dout}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   // Outputs forced to zero while idle so the unreset FIFO storage never leaks.
   assign ioctl_wr = !empty;
   assign {ioctl_ram, ioctl_addr, ioctl_dout} = empty ? '0 : fifo_dout;

   // Wait is computed from the post-edge occupancy so it rises together with
   // the count reaching depth-1, leaving room for one in-flight write.
   assign count_nxt = count + CW'(push && !full) - CW'(pop);

   always_comb begin
      hps_wait_d = hps_wait_q;
      if (count_nxt >= CW'(DEPTH - 1))      hps_wait_d = 1'b1;
      else if (count_nxt <= CW'(DEPTH - 2)) hps_wait_d = 1'b0;
   end

   always_comb begin
      downloading_d = downloading_q;
      pend_end_d    = pend_end_q;
      wr_seen_d     = wr_seen_q;
      cnt_d         = cnt_q;
      dwn_len_d     = dwn_len_q;
      dwn_empty_d   = dwn_empty_q;
      if (pend_end_q && empty) begin
         downloading_d = 1'b0;
         dwn_len_d     = cnt_q;
         dwn_empty_d   = !wr_seen_q;
         pend_end_d    = 1'b0;
      end
      // Only an active ROM download may end; NVRAM/DIP edges leave status alone.
      if (fall && downloading_q) pend_end_d = 1'b1;
      if (rise && (hps_index == IDX_ROM)) begin
         downloading_d = 1'b1;
         cnt_d         = '0;
         wr_seen_d     = 1'b0;
         dwn_empty_d   = 1'b0;
         pend_end_d    = 1'b0;
      end
      if (is_rom) begin
         cnt_d     = cnt_d + AW'(STEP);
         wr_seen_d = 1'b1;
      end
   end

   always_comb begin
      core_mod_d = core_mod_q;
      dipsw_d    = dipsw_q;
      if (hps_wr && (hps_index == IDX_MOD) && !hps_addr[0]) core_mod_d = hps_dout[6:0];
      if (hps_wr && (hps_index == IDX_DIPSW)) begin
         for (int unsigned i = 0; i < DIPB; i++) begin
            if (hps_addr == AW'(i)) dipsw_d[i*8 +: 8] = hps_dout[7:0];
            // high byte of a 16-bit word lands on the next byte address
            if ((DW == 16) && (i > 0) && (hps_addr == AW'(i - 1)))
               dipsw_d[i*8 +: 8] = hps_dout[DW-1 -: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hps_wait_q    <= 1'b0;
         last_dwn_q    <= 1'b0;
         downloading_q <= 1'b0;
         pend_end_q    <= 1'b0;
         wr_seen_q     <= 1'b0;
         cnt_q         <= '0;
         dwn_len_q     <= '0;
         dwn_empty_q   <= 1'b0;
         core_mod_q    <= MOD_RST;
         dipsw_q       <= '1;
      end else begin
         hps_wait_q    <= hps_wait_d;
         last_dwn_q    <= hps_download;
         downloading_q <= downloading_d;
         pend_end_q    <= pend_end_d;
         wr_seen_q     <= wr_seen_d;
         cnt_q         <= cnt_d;
         dwn_len_q     <= dwn_len_d;
         dwn_empty_q   <= dwn_empty_d;
         core_mod_q    <= core_mod_d;
         dipsw_q       <= dipsw_d;
      end
   end

   assign hps_wait    = hps_wait_q;
   assign downloading = downloading_q;
   assign dwn_len     = dwn_len_q;
   assign dwn_empty   = dwn_empty_q;
   assign core_mod    = core_mod_q;
   assign dipsw       = dipsw_q;

`ifdef SIMULATION
   logic ovf_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              ovf_q <= 1'b0;
      else if (push && full) ovf_q <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_jtframe_hps_loader.sv
module tb_jtframe_hps_loader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT A: DW=8 defaults
   logic        a_dwn = 0, a_wr = 0, a_rdy = 1;
   logic [7:0]  a_idx = 0;
   logic [26:0] a_addr = 0;
   logic [7:0]  a_dout = 0;
   logic        a_wait, a_iwr, a_iram, a_dl, a_dempty;
   logic [26:0] a_iaddr, a_dlen;
   logic [7:0]  a_idout;
   logic [6:0]  a_mod;
   logic [31:0] a_dip;

   // DUT B: DW=16
   logic        b_dwn = 0, b_wr = 0, b_rdy = 1;
   logic [7:0]  b_idx = 0;
   logic [26:0] b_addr = 0;
   logic [15:0] b_dout = 0;
   logic        b_wait, b_iwr, b_iram, b_dl, b_dempty;
   logic [26:0] b_iaddr, b_dlen;
   logic [15:0] b_idout;
   logic [6:0]  b_mod;
   logic [31:0] b_dip;

   jtframe_hps_loader u_dut (
      .clk(clk), .rst(rst), .hps_download(a_dwn), .hps_index(a_idx), .hps_wr(a_wr),
      .hps_addr(a_addr), .hps_dout(a_dout), .hps_wait(a_wait), .ioctl_wr(a_iwr),
      .ioctl_ram(a_iram), .ioctl_addr(a_iaddr), .ioctl_dout(a_idout), .ioctl_rdy(a_rdy),
      .downloading(a_dl), .dwn_len(a_dlen), .dwn_empty(a_dempty), .core_mod(a_mod),
      .dipsw(a_dip)
   );

   jtframe_hps_loader #(.DW(16), .DIPB(4)) u_dut16 (
      .clk(clk), .rst(rst), .hps_download(b_dwn), .hps_index(b_idx), .hps_wr(b_wr),
      .hps_addr(b_addr), .hps_dout(b_dout), .hps_wait(b_wait), .ioctl_wr(b_iwr),
      .ioctl_ram(b_iram), .ioctl_addr(b_iaddr), .ioctl_dout(b_idout), .ioctl_rdy(b_rdy),
      .downloading(b_dl), .dwn_len(b_dlen), .dwn_empty(b_dempty), .core_mod(b_mod),
      .dipsw(b_dip)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model for DUT A: a queue of pending words plus download status.
   typedef struct {
      bit          ram;
      int unsigned addr;
      int unsigned data;
   } ent_t;

   ent_t        q[$];
   bit          m_wait, m_dl, m_pend, m_seen, m_dempty, m_last;
   int unsigned m_cnt, m_len;
   bit [6:0]    m_mod;
   bit [31:0]   m_dip;

   task automatic model_reset();
      q.delete();
      m_wait = 0; m_dl = 0; m_pend = 0; m_seen = 0; m_dempty = 0; m_last = 0;
      m_cnt = 0; m_len = 0; m_mod = 7'd1; m_dip = '1;
   endtask

   task automatic model_update();
      int unsigned pre = q.size();
      if (m_pend && pre == 0) begin
         m_dl = 0; m_len = m_cnt; m_dempty = !m_seen; m_pend = 0;
      end
      if (!a_dwn && m_last && m_dl) m_pend = 1;
      if (a_dwn && !m_last && a_idx == 8'd0) begin
         m_dl = 1; m_cnt = 0; m_seen = 0; m_dempty = 0; m_pend = 0;
      end
      if (a_wr && a_idx == 8'd0) begin
         m_cnt = (m_cnt + 1) % (1 << 27);
         m_seen = 1;
      end
      if (a_wr && a_idx == 8'd1 && !a_addr[0]) m_mod = a_dout[6:0];
      if (a_wr && a_idx == 8'd254 && a_addr < 4) m_dip[a_addr*8 +: 8] = a_dout;
      m_last = a_dwn;
      if (pre != 0 && a_rdy) void'(q.pop_front());
      if (a_wr && (a_idx == 8'd0 || a_idx == 8'd2) && pre < 4)
         q.push_back('{ram: (a_idx == 8'd2), addr: a_addr, data: a_dout});
      m_wait = (q.size() >= 3);
   endtask

   task automatic compare();
      check("ioctl_wr", a_iwr, q.size() != 0);
      if (q.size() != 0) begin
         check("ioctl_addr", a_iaddr, q[0].addr);
         check("ioctl_dout", a_idout, q[0].data);
         check("ioctl_ram", a_iram, q[0].ram);
      end
      check("hps_wait", a_wait, m_wait);
      check("downloading", a_dl, m_dl);
      check("dwn_len", a_dlen, m_len);
      check("dwn_empty", a_dempty, m_dempty);
      check("core_mod", a_mod, m_mod);
      check("dipsw", a_dip, m_dip);
   endtask

   // One clock: inputs already set; compare before the edge, advance model.
   task automatic step();
      @(negedge clk);
      compare();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_wait"}, a_wait, 0);
      check({tag, "_iwr"}, a_iwr, 0);
      check({tag, "_iram"}, a_iram, 0);
      check({tag, "_iaddr"}, a_iaddr, 0);
      check({tag, "_idout"}, a_idout, 0);
      check({tag, "_dl"}, a_dl, 0);
      check({tag, "_dlen"}, a_dlen, 0);
      check({tag, "_dempty"}, a_dempty, 0);
      check({tag, "_mod"}, a_mod, 7'd1);
      check({tag, "_dip"}, a_dip, 32'hffff_ffff);
   endtask

   task automatic tick_b();
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_a("rst");
      check("rst_b_dip", b_dip, 32'hffff_ffff);
      check("rst_b_iwr", b_iwr, 0);
      rst = 0;

      // 1: ROM download, 16 bytes, loader always ready
      a_idx = 8'd0; a_dwn = 1; step();
      for (int i = 0; i < 16; i++) begin
         a_wr = 1; a_addr = 27'(i); a_dout = 8'($urandom);
         step();
      end
      a_wr = 0; step();
      a_dwn = 0;
      repeat (4) step();
      check("t1_dwn_len", a_dlen, 16);
      check("t1_dwn_empty", a_dempty, 0);
      check("t1_downloading", a_dl, 0);

      // 2: back-pressure with loader stalled
      a_dwn = 1; step();
      a_rdy = 0;
      for (int i = 0; i < 4; i++) begin
         a_wr = 1; a_addr = 27'(i); a_dout = 8'($urandom);
         step();
      end
      a_wr = 0;
      check("t2_wait_full", a_wait, 1);
      repeat (3) step();
`ifdef SIMULATION
      check("t2_no_ovf", u_dut.ovf_q, 0);
`endif
      a_rdy = 1;
      repeat (5) step();

      // 3: download ends while words are still queued
      a_rdy = 0;
      for (int i = 4; i < 7; i++) begin
         a_wr = 1; a_addr = 27'(i); a_dout = 8'($urandom);
         step();
      end
      a_wr = 0; a_dwn = 0;
      repeat (4) step();
      check("t3_hold_dl", a_dl, 1);
      for (int i = 0; i < 8; i++) begin
         a_rdy = 1'($urandom);
         step();
      end
      a_rdy = 1;
      repeat (4) step();
      check("t3_dwn_len", a_dlen, 7);
      check("t3_downloading", a_dl, 0);

      // random traffic across all indices
      for (int i = 0; i < 400; i++) begin
         int unsigned sel = $urandom_range(0, 5);
         if ($urandom_range(0, 15) == 0) a_dwn = !a_dwn;
         a_idx  = (sel <= 1) ? 8'd0 : (sel == 2) ? 8'd2 : (sel == 3) ? 8'd1 :
                  (sel == 4) ? 8'd254 : 8'd9;
         a_wr   = !m_wait && ($urandom_range(0, 2) != 0);
         a_addr = 27'($urandom_range(0, 5));
         a_dout = 8'($urandom);
         a_rdy  = ($urandom_range(0, 3) != 0);
         step();
      end
      a_wr = 0; a_dwn = 0; a_rdy = 1; a_idx = 8'd0;
      repeat (8) step();

      // 4: empty ROM download
      a_dwn = 1; step();
      check("t4_dl_up", a_dl, 1);
      a_dwn = 0;
      repeat (3) step();
      check("t4_dl_down", a_dl, 0);
      check("t4_dwn_empty", a_dempty, 1);
      check("t4_dwn_len", a_dlen, 0);

      // 6: NVRAM word held by a stalled loader, then reset
      a_rdy = 0; a_idx = 8'd2; a_wr = 1; a_addr = 27'd3; a_dout = 8'h5a;
      step();
      a_wr = 0;
      check("t6_ram", a_iram, 1);
      check("t6_iwr", a_iwr, 1);
      check("t6_dout", a_idout, 8'h5a);
      rst = 1;
      #1;
      check_reset_a("t6");
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
      a_rdy = 1;
      repeat (4) step();
      check("t6_no_wr", a_iwr, 0);

      // 5: DW=16 instance, DIP bank and core_mod
      b_wr = 1; b_idx = 8'd254; b_addr = 27'd0; b_dout = 16'h1234; tick_b();
      b_addr = 27'd2; b_dout = 16'h5678; tick_b();
      b_addr = 27'd4; b_dout = 16'habcd; tick_b();
      b_wr = 0;
      check("t5_dipsw", b_dip, 32'h5678_1234);
      b_wr = 1; b_idx = 8'd1; b_addr = 27'd0; b_dout = 16'h0005; tick_b();
      b_wr = 0;
      check("t5_mod", b_mod, 7'd5);
      b_wr = 1; b_addr = 27'd1; b_dout = 16'h0007; tick_b();
      b_wr = 0;
      check("t5_mod_odd", b_mod, 7'd5);

      // DW=16 ROM download counts two bytes per word
      b_idx = 8'd0; b_dwn = 1; tick_b();
      b_wr = 1; b_addr = 27'd0; b_dout = 16'hbeef; tick_b();
      b_wr = 0;
      check("t5_iwr", b_iwr, 1);
      check("t5_idout", b_idout, 16'hbeef);
      check("t5_iaddr", b_iaddr, 0);
      for (int i = 1; i < 3; i++) begin
         b_wr = 1; b_addr = 27'(2 * i); b_dout = 16'($urandom); tick_b();
      end
      b_wr = 0; b_dwn = 0;
      repeat (6) tick_b();
      check("t5_dwn_len", b_dlen, 6);
      check("t5_dwn_empty", b_dempty, 0);
      check("t5_downloading", b_dl, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/jtframe_hps_loader.md
Name: jtframe_hps_loader

Overview:
- Next-generation MiSTer HPS download router, placed between the hps_io block and the core's SDRAM/ROM loader.
- Demultiplexes HPS writes by menu index into four destinations:
  - the ROM stream and the NVRAM stream, both buffered in a FIFO;
  - the core_mod register;
  - a parametrised DIP-switch bank.
- Adds features the previous generation lacked:
  - back-pressure via hps_wait when the downstream loader stalls;
  - a generic data width (8 or 16 bits);
  - download length reporting.

Parameters:
- DW, 8, HPS/ioctl data width; legal values 8 or 16. In 16-bit mode hps_addr steps by 2.
- AW, 27, address width.
- FIFO_AW, 2, log2 of FIFO depth (depth 4 by default).
- DIPB, 4, number of DIP-switch bytes; legal range 1..8.
- IDX_ROM, 8'd0, menu index for ROM.
- IDX_MOD, 8'd1, menu index for core_mod.
- IDX_NVRAM, 8'd2, menu index for NVRAM.
- IDX_DIPSW, 8'd254, menu index for DIP switches.
- MOD_RST, 7'b1, reset value of core_mod.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- hps_download  in  1  download active.
- hps_index  in  8  menu index.
- hps_wr  in  1  write strobe, one cycle.
- hps_addr  in  AW  byte address.
- hps_dout  in  DW  write data.
- hps_wait  out  1  stall request to HPS.
- ioctl_wr  out  1  write strobe to loader.
- ioctl_ram  out  1  current ioctl_wr carries NVRAM data.
- ioctl_addr  out  AW  loader address.
- ioctl_dout  out  DW  loader data.
- ioctl_rdy  in  1  loader accepts the presented word this cycle.
- downloading  out  1  ROM download in progress.
- dwn_len  out  AW  bytes received in the last ROM download.
- dwn_empty  out  1  last ROM download carried no data.
- core_mod  out  7  core mode bits.
- dipsw  out  8*DIPB  DIP-switch bank.

Behaviour:

Reset values:
- hps_wait=0, ioctl_wr=0, ioctl_ram=0, ioctl_addr=0, ioctl_dout=0.
- downloading=0, dwn_len=0, dwn_empty=0.
- core_mod=MOD_RST, dipsw all ones.
- FIFO empty; edge detector last_dwn=0.

Index decode:
- Uses hps_index sampled in the same cycle as hps_wr.
- Writes with any unlisted index are ignored.

FIFO:
- Each entry is {ram_flag, addr, data}.
- A push occurs on hps_wr with index ROM or NVRAM; ram_flag = (index==IDX_NVRAM).
- Push and pop in the same cycle are legal; the count is unchanged.
- A push while full is dropped and sets an internal sticky ovf bit. It is a verification-only signal, exposed under SIMULATION.

Output handshake:
- Head of the FIFO is presented registered: ioctl_wr=1 whenever the FIFO is non-empty.
- addr, dout and ram stay stable while ioctl_rdy=0.
- Pop on ioctl_wr && ioctl_rdy.
- Latency: push in cycle N gives ioctl_wr high in cycle N+1 if the FIFO was empty.

Back-pressure:
- hps_wait is registered and set when count >= depth-1.
- It clears when count <= depth-2.
- Guarantees that one in-flight write after assertion still fits.

core_mod:
- Loaded from hps_dout[6:0] on hps_wr && index==IDX_MOD && hps_addr[0]==0.
- In DW=16 mode only the low byte is used.

DIP bank:
- On hps_wr && index==IDX_DIPSW && address < DIPB, byte hps_addr is written.
- In DW=16 mode bytes addr and addr+1 are both written when in range; the high byte goes to addr+1.
- Out-of-range addresses are ignored.

Download tracking (rising and falling edges of hps_download, via last_dwn):
- Rising edge with index==IDX_ROM:
  - downloading=1, byte counter cleared, wr_seen=0, dwn_empty=0.
- Each ROM push adds DW/8 to the byte counter (wraps at 2^AW) and sets wr_seen.
- Falling edge sets pend_end.
- While pend_end && FIFO empty:
  - downloading=0;
  - dwn_len = counter;
  - dwn_empty = !wr_seen;
  - pend_end cleared.
- downloading therefore never drops before the last word has been accepted.
- A rising edge during pend_end restarts tracking; the pending end is discarded.
- NVRAM and DIP downloads never touch downloading or dwn_len.

Reset mid-download:
- All state returns to the reset values immediately; FIFO contents are discarded.

Decomposition:
- Shared package jtframe_hps_pkg holds:
  - the IDX_* localparams;
  - the DW-legality check;
  - the entry-width function (1+AW+DW).
- One sub-module: jtframe_hps_fifo, a generic synchronous FIFO with parameters width and FIFO_AW.
  - Outputs count, full and empty.
  - Used here and reusable elsewhere in the codebase.

Test Plan:
1. ROM download, DW=8, ioctl_rdy=1: 16 writes at addr 0..15.
   - Expected: 16 ioctl_wr pulses, each one cycle after its push, with matching addr and data.
   - downloading falls 1 cycle after FIFO empty following download fall; dwn_len=16, dwn_empty=0.
2. Back-pressure: ioctl_rdy=0, 4 writes on consecutive cycles.
   - Expected: hps_wait=1 after count reaches 3; the 4th write is stored; no overflow.
   - Releasing ioctl_rdy drains the 4 words in order; hps_wait drops at count 2.
3. Early end: download falls while 3 words are still queued.
   - Expected: downloading stays 1 until the last pop, then 0; dwn_len=total bytes.
4. Empty download: ROM download rises then falls with no hps_wr.
   - Expected: downloading 1 then 0; dwn_empty=1; dwn_len=0.
5. DW=16, DIPB=4: DIP writes addr 0 data 16'h12_34 and addr 2 data 16'h56_78, plus a write at addr 4.
   - Expected: dipsw=32'h5678_1234; the addr-4 write is ignored.
   - core_mod write with addr 0 data 16'h0005 gives core_mod=5; a write at addr 1 leaves it unchanged.
6. NVRAM write during ioctl stall, then rst pulse with the FIFO non-empty.
   - Expected: ioctl_ram=1 with that entry; after rst all outputs return to reset values and no further ioctl_wr occurs.
